// File: rtl/tx_burst_scheduler.sv
// TDMA slot scheduler for the GMSK burst transmitter: slot/frame timing, mask-driven fire
// decisions, missed-slot and overrun reporting. Optional one-shot masks: TX_SCHED_ONESHOT_EN.
module tx_burst_scheduler #(
  parameter int unsigned CLOCKS_PER_SLOT = 2500,
  parameter int unsigned SLOTS_PER_FRAME = 8,
  parameter int unsigned FIRE_OFFSET     = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               cfg_we,
  input  logic [SLOTS_PER_FRAME-1:0]         cfg_slot_mask,
  input  logic                               is_armed,
  input  logic                               iq_valid,
  output logic                               fire_burst,
  output logic                               slot_strobe,
  output logic [$clog2(SLOTS_PER_FRAME)-1:0] slot_index,
  output logic [7:0]                         frame_count,
  output logic                               burst_active,
  output logic [7:0]                         missed_count,
  output logic                               overrun
);

  localparam int unsigned TMR_W  = $clog2(CLOCKS_PER_SLOT);
  localparam int unsigned SLOT_W = $clog2(SLOTS_PER_FRAME);
  localparam int unsigned MASK_W = SLOTS_PER_FRAME;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLOCKS_PER_SLOT - 1);
  localparam logic [TMR_W-1:0]  TMR_DP    = TMR_W'(FIRE_OFFSET);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FIRE,
    S_START,
    S_RUN,
    S_DRAIN_S,
    S_DRAIN_R
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                tmr_run;
  logic [TMR_W-1:0]    slot_timer;
  logic [MASK_W-1:0]   shadow_mask;
  logic [MASK_W-1:0]   active_mask;
  logic [MASK_W-1:0]   mask_eff_c;
  logic [MASK_W-1:0]   clr_c;
  logic                copy_now_c;
  logic                dp_c;
  logic                slot_bit_c;
  logic                fire_go_c;
  logic                miss_c;
  logic                ovr_set_c;
  logic                fire_nxt_c;
  logic                busy_nxt_c;

  // Slot timer: the first cycle after enable is sampled high is slot 0, timer 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_run     <= 1'b0;
      slot_timer  <= '0;
      slot_index  <= '0;
      frame_count <= '0;
      slot_strobe <= 1'b0;
    end else if (!enable) begin
      tmr_run     <= 1'b0;
      slot_timer  <= '0;
      slot_index  <= '0;
      frame_count <= '0;
      slot_strobe <= 1'b0;
    end else if (!tmr_run) begin
      tmr_run     <= 1'b1;
      slot_timer  <= '0;
      slot_index  <= '0;
      frame_count <= '0;
      slot_strobe <= 1'b1;
    end else if (slot_timer == TMR_LAST) begin
      slot_timer  <= '0;
      slot_strobe <= 1'b1;
      if (slot_index == SLOT_LAST) begin
        slot_index  <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        slot_index <= slot_index + SLOT_W'(1);
      end
    end else begin
      slot_timer  <= slot_timer + TMR_W'(1);
      slot_strobe <= 1'b0;
    end
  end

  // Mask seen by this cycle's decision: the shadow on a copy cycle, otherwise the active copy.
  always_comb begin
    copy_now_c = !enable || (slot_strobe && (slot_index == '0));
    mask_eff_c = copy_now_c ? shadow_mask : active_mask;
    slot_bit_c = mask_eff_c[slot_index];
    dp_c       = tmr_run && (slot_timer == TMR_DP);
  end

`ifdef TX_SCHED_ONESHOT_EN
  always_comb begin
    clr_c = '0;
    if (fire_go_c) begin
      clr_c = MASK_W'(1) << slot_index;
    end
  end
`else
  always_comb begin
    clr_c = '0;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_mask <= '0;
      active_mask <= '0;
    end else begin
      shadow_mask <= cfg_we ? cfg_slot_mask : (shadow_mask & ~clr_c);
      active_mask <= mask_eff_c & ~clr_c;
    end
  end

  // Burst handshake FSM: next state plus registered-output next values.
  always_comb begin
    state_nxt = state;
    fire_go_c = 1'b0;
    miss_c    = 1'b0;
    ovr_set_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (dp_c && slot_bit_c) begin
          if (is_armed) begin
            state_nxt = S_FIRE;
            fire_go_c = 1'b1;
          end else begin
            miss_c = 1'b1;
          end
        end
      end
      S_FIRE: begin
        state_nxt = enable ? S_START : S_DRAIN_S;
      end
      S_START: begin
        if (!enable) begin
          state_nxt = iq_valid ? S_DRAIN_R : S_DRAIN_S;
        end else if (iq_valid) begin
          state_nxt = S_RUN;
        end
        if (slot_strobe && enable) begin
          ovr_set_c = 1'b1;
          miss_c    = slot_bit_c;
        end
      end
      S_RUN: begin
        if (!iq_valid) begin
          state_nxt = enable ? S_WAIT : S_IDLE;
        end else if (!enable) begin
          state_nxt = S_DRAIN_R;
        end
        if (slot_strobe && enable) begin
          ovr_set_c = 1'b1;
          miss_c    = slot_bit_c;
        end
      end
      S_DRAIN_S: begin
        if (iq_valid) begin
          state_nxt = S_DRAIN_R;
        end
      end
      S_DRAIN_R: begin
        if (!iq_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    fire_nxt_c = (state_nxt == S_FIRE);
    busy_nxt_c = (state_nxt == S_FIRE) || (state_nxt == S_START) || (state_nxt == S_RUN) ||
                 (state_nxt == S_DRAIN_S) || (state_nxt == S_DRAIN_R);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      fire_burst   <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      fire_burst   <= fire_nxt_c;
      burst_active <= busy_nxt_c;
    end
  end

  // Overrun clears on the enable falling edge; missed_count saturates and clears only on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun      <= 1'b0;
      missed_count <= '0;
    end else begin
      if (tmr_run && !enable) begin
        overrun <= 1'b0;
      end else if (ovr_set_c) begin
        overrun <= 1'b1;
      end
      if (miss_c && (missed_count != 8'hFF)) begin
        missed_count <= missed_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Directed bench for tx_burst_scheduler (20 clocks/slot, 4 slots/frame, decision at timer 2).
module tb_tx_burst_scheduler;

  localparam int unsigned CPS = 20;
  localparam int unsigned SPF = 4;
  localparam int unsigned FOF = 2;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       cfg_we;
  logic [3:0] cfg_slot_mask;
  logic       is_armed;
  logic       iq_valid;
  logic       fire_burst;
  logic       slot_strobe;
  logic [1:0] slot_index;
  logic [7:0] frame_count;
  logic       burst_active;
  logic [7:0] missed_count;
  logic       overrun;

  tx_burst_scheduler #(
    .CLOCKS_PER_SLOT(CPS),
    .SLOTS_PER_FRAME(SPF),
    .FIRE_OFFSET    (FOF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .cfg_we       (cfg_we),
    .cfg_slot_mask(cfg_slot_mask),
    .is_armed     (is_armed),
    .iq_valid     (iq_valid),
    .fire_burst   (fire_burst),
    .slot_strobe  (slot_strobe),
    .slot_index   (slot_index),
    .frame_count  (frame_count),
    .burst_active (burst_active),
    .missed_count (missed_count),
    .overrun      (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string      name;
    int         ncyc;
    logic       en;
    logic       strobe;
    logic [1:0] idx;
    logic [7:0] frame;
  } vec_t;

  vec_t tbl[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   fire_cnt = 0;
  int   f0;
  int   nf;
  int   p;

  // Counts fire pulses of the cycle that just ended.
  always @(posedge clock) begin
    if (fire_burst === 1'b1) fire_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    enable        = 1'b0;
    cfg_we        = 1'b0;
    cfg_slot_mask = 4'b0000;
    is_armed      = 1'b0;
    iq_valid      = 1'b0;
    reset         = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic load_mask(input logic [3:0] m);
    cfg_we        = 1'b1;
    cfg_slot_mask = m;
    step(1);
    cfg_we = 1'b0;
    step(1);
  endtask

  task automatic add(input string nm, input int n, input logic en, input logic st,
                     input logic [1:0] ix, input logic [7:0] fr);
    vec_t v;
    v.name = nm; v.ncyc = n; v.en = en; v.strobe = st; v.idx = ix; v.frame = fr;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    // Timing table; cycle c = (clock edges since enable was sampled high) - 1.
    add("rst",  1,  1'b0, 1'b0, 2'd0, 8'd0);
    add("c0",   1,  1'b1, 1'b1, 2'd0, 8'd0);
    add("c1",   1,  1'b1, 1'b0, 2'd0, 8'd0);
    add("c19",  18, 1'b1, 1'b0, 2'd0, 8'd0);
    add("c20",  1,  1'b1, 1'b1, 2'd1, 8'd0);
    add("c40",  20, 1'b1, 1'b1, 2'd2, 8'd0);
    add("c60",  20, 1'b1, 1'b1, 2'd3, 8'd0);
    add("c79",  19, 1'b1, 1'b0, 2'd3, 8'd0);
    add("c80",  1,  1'b1, 1'b1, 2'd0, 8'd1);
    add("c160", 80, 1'b1, 1'b1, 2'd0, 8'd2);
    add("c199", 39, 1'b1, 1'b0, 2'd1, 8'd2);
    add("dis",  1,  1'b0, 1'b0, 2'd0, 8'd0);
    add("dis5", 5,  1'b0, 1'b0, 2'd0, 8'd0);

    do_reset();
    f0 = fire_cnt;
    foreach (tbl[i]) begin
      enable = tbl[i].en;
      step(tbl[i].ncyc);
      chk({tbl[i].name, ".strobe"}, slot_strobe, tbl[i].strobe);
      chk({tbl[i].name, ".idx"},    slot_index,  tbl[i].idx);
      chk({tbl[i].name, ".frame"},  frame_count, tbl[i].frame);
      chk({tbl[i].name, ".fire"},   fire_burst,  1'b0);
      chk({tbl[i].name, ".busy"},   burst_active, 1'b0);
      chk({tbl[i].name, ".missed"}, missed_count, 8'd0);
      chk({tbl[i].name, ".ovr"},    overrun,     1'b0);
    end
    chk("timing.fires", fire_cnt - f0, 0);

    // Scheduled fire in slots 0 and 2, 8-cycle iq_valid pulse 3 cycles after fire.
    do_reset();
    load_mask(4'b0101);
    is_armed = 1'b1;
    enable   = 1'b1;
    step(1);
    for (int c = 0; c < 160; c++) begin
      p = c % 40;
      chk("sched.fire", fire_burst, (p == 3));
      chk("sched.busy", burst_active, (p >= 3 && p <= 14));
      iq_valid = (p >= 6 && p <= 13);
      step(1);
    end
    chk("sched.missed", missed_count, 8'd0);
    chk("sched.ovr", overrun, 1'b0);

    // Unarmed slot 1: one miss per frame, saturating at 255.
    do_reset();
    load_mask(4'b0010);
    enable = 1'b1;
    step(1);
    f0 = fire_cnt;
    step(22);
    chk("unarmed.c22", missed_count, 8'd0);
    step(1);
    chk("unarmed.c23", missed_count, 8'd1);
    step(216);
    chk("unarmed.3frames", missed_count, 8'd3);
    step(80 * 253);
    chk("unarmed.sat", missed_count, 8'd255);
    chk("unarmed.fires", fire_cnt - f0, 0);
    chk("unarmed.ovr", overrun, 1'b0);

    // Overrun: slot-0 burst runs across the slot-1 boundary.
    do_reset();
    load_mask(4'b0011);
    is_armed = 1'b1;
    enable   = 1'b1;
    step(1);
    nf = 0;
    for (int c = 0; c < 80; c++) begin
      if (fire_burst === 1'b1) nf++;
      if (c == 19) chk("ovr.c19", overrun, 1'b0);
      if (c == 21) begin
        chk("ovr.c21", overrun, 1'b1);
        chk("ovr.missed", missed_count, 8'd1);
      end
      if (c == 40) chk("ovr.busy_c40", burst_active, 1'b0);
      iq_valid = (c >= 6 && c <= 35);
      step(1);
    end
    chk("ovr.frame_fires", nf, 1);

    // Disable two cycles into RUN of the next frame's slot-0 burst.
    for (int c = 80; c <= 110; c++) begin
      chk("dis.fire", fire_burst, (c == 83));
      chk("dis.busy", burst_active, (c >= 83 && c <= 101));
      chk("dis.ovr", overrun, (c <= 88));
      if (c >= 89) chk("dis.idx", slot_index, 2'd0);
      iq_valid = (c >= 86 && c <= 100);
      if (c == 88) enable = 1'b0;
      step(1);
    end
    chk("dis.missed", missed_count, 8'd1);
    chk("dis.frame", frame_count, 8'd0);

    // Async reset during the FIRE cycle.
    do_reset();
    load_mask(4'b0001);
    enable = 1'b1;
    step(1);
    step(79);
    is_armed = 1'b1;
    step(4);
    chk("ar.pre_fire", fire_burst, 1'b1);
    chk("ar.pre_frame", frame_count, 8'd1);
    chk("ar.pre_missed", missed_count, 8'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar.fire", fire_burst, 1'b0);
    chk("ar.busy", burst_active, 1'b0);
    chk("ar.missed", missed_count, 8'd0);
    chk("ar.frame", frame_count, 8'd0);
    chk("ar.idx", slot_index, 2'd0);
    chk("ar.strobe", slot_strobe, 1'b0);
    step(1);
    reset = 1'b0;
    f0 = fire_cnt;
    step(100);
    chk("ar.post_fires", fire_cnt - f0, 0);
    chk("ar.post_missed", missed_count, 8'd0);

    // Slot-3 mask over two frames: once in one-shot builds, every frame otherwise.
    do_reset();
    load_mask(4'b1000);
    is_armed = 1'b1;
    enable   = 1'b1;
    step(1);
    nf = 0;
    for (int c = 0; c < 160; c++) begin
      if (fire_burst === 1'b1) nf++;
      p = c % 80;
      iq_valid = (p >= 66 && p <= 73);
      step(1);
    end
`ifdef TX_SCHED_ONESHOT_EN
    chk("oneshot.fires", nf, 1);
`else
    chk("persist.fires", nf, 2);
`endif
    chk("slot3.ovr", overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
